instruction_fetch_queue: RTL and testbench
==========================================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning PC width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; a power of 2 and at least 2.
REQ-004 SHALL have parameter PC_STEP, default 1, meaning PC increment per accepted word.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port DIR, input, 1 bit, meaning upstream data_in is valid.
REQ-008 SHALL have port data_in, input, DATA_W bits, meaning the upstream instruction word.
REQ-009 SHALL have port ack_prev, output, 1 bit, meaning a one-cycle pulse that the word was accepted.
REQ-010 SHALL have port DOR, output, 1 bit, meaning the queue head is valid.
REQ-011 SHALL have port data_out, output, DATA_W bits, meaning the head instruction word.
REQ-012 SHALL have port pc_out, output, ADDR_W bits, meaning the PC tagged to the head word.
REQ-013 SHALL have port ack_from_next, input, 1 bit, meaning downstream consumed the head.
REQ-014 SHALL have port flush, input, 1 bit, meaning redirect request (branch/jump).
REQ-015 SHALL have port flush_pc, input, ADDR_W bits, meaning the redirect target.
REQ-016 SHALL have port fetch_pc, output, ADDR_W bits, meaning the PC of the next word to accept.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits, meaning the current occupancy.

Function
REQ-018 SHALL run FSM states EMPTY, ACTIVE, FULL and FLUSH, all registered.
REQ-019 SHALL accept a word on an edge where DIR=1, state is not FULL or FLUSH, ack_prev=0 and flush=0.
REQ-020 SHALL write the accepted word to the tail as {fetch_pc, data_in}, set fetch_pc <= fetch_pc+PC_STEP mod 2^ADDR_W, and drive ack_prev=1 for the following cycle only.
REQ-021 SHALL drive ack_prev=0 in every other cycle, so back-to-back accepts occur at most every second cycle.
REQ-022 SHALL drive DOR=1 iff count>0 and the state is not FLUSH; data_out and pc_out are the head entry; latency from accept edge to DOR is 1 cycle.
REQ-023 SHALL pop the head on an edge where DOR=1 and ack_from_next=1; ack_from_next while DOR=0 is ignored.
REQ-024 SHALL, on simultaneous accept and pop, update both pointers and leave count unchanged.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL follow these transitions: EMPTY->ACTIVE on accept; ACTIVE->FULL when count reaches DEPTH; ACTIVE->EMPTY when count reaches 0; FULL->ACTIVE on pop.
REQ-027 SHALL hold data_out and pc_out stable while DOR=1 and ack_from_next=0.
REQ-028 SHALL give flush=1 priority over accept and pop in any state: discard all entries (count=0), set fetch_pc <= flush_pc and ack_prev <= 0, and enter FLUSH.
REQ-029 SHALL leave FLUSH for EMPTY after exactly one cycle unless flush is still 1; no accept occurs in FLUSH.
REQ-030 SHALL never overwrite an entry when FULL and never decrement count below 0.

Reset
REQ-031 SHALL, on reset=1 (asynchronous, any state, including mid-handshake), set state=EMPTY, count=0, both pointers=0, fetch_pc=0, ack_prev=0, DOR=0, data_out=0 and pc_out=0.
REQ-032 SHALL leave queue storage contents unreset; they are unobservable while count=0.
REQ-033 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-034 SHALL put the FSM state encoding (2-bit) and the default widths in a shared package, fetch_pkg, used by the later pipeline stages.
REQ-035 SHALL contain one sub-module, fetch_queue_mem: a DEPTH x (ADDR_W+DATA_W) register array with one write port and one asynchronous read port.

Verification
REQ-036 Reset then DIR=1 with data_in=0x11 -> ack_prev pulses at cycle 1; DOR=1, data_out=0x11, pc_out=0 and fetch_pc=1 at cycle 1.
REQ-037 Five words 0xA0..0xA4 with ack_from_next=0 (DEPTH=4) -> 4 accepts, count=4, state FULL, and 0xA4 gets no ack_prev until one pop, then is accepted with pc=4.
REQ-038 With fetch_pc=0xFF (ADDR_W=8), accept one word -> its pc_out=0xFF and fetch_pc=0x00.
REQ-039 Two entries queued plus flush=1, flush_pc=0x40 on the same edge as DIR=1 and ack_from_next=1 -> count=0, DOR=0 for one cycle, no ack_prev, and the next accepted word has pc_out=0x40.
REQ-040 Continuous DIR=1 and ack_from_next=1 -> a steady state of one word every 2 cycles, count stays at most 1, and pc_out sequence is 0,1,2,3.
REQ-041 Assert reset asynchronously between clock edges while count=3 -> DOR, ack_prev and count are 0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: queue FSM encoding, default widths and a
// helper that maps an occupancy to its steady FSM state. Later pipeline
// stages import this for the same defaults.
package fetch_pkg;

  localparam int FETCH_DATA_W  = 8;
  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_PC_STEP = 1;

  typedef enum logic [1:0] {
    FQ_EMPTY  = 2'd0,
    FQ_ACTIVE = 2'd1,
    FQ_FULL   = 2'd2,
    FQ_FLUSH  = 2'd3
  } fq_state_t;

  // Outside of a flush the state is purely a function of occupancy.
  function automatic fq_state_t fq_occ_state(input int occ, input int depth);
    if (occ == 0)          return FQ_EMPTY;
    else if (occ >= depth) return FQ_FULL;
    else                   return FQ_ACTIVE;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W register array, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
//   clk   - clock
//   we    - write enable
//   waddr - write index, wdata - write word
//   raddr - read index,  rdata - combinational read word
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: accepts instruction words from upstream with a
// one-cycle ack pulse, tags each with its PC, and presents the oldest entry
// downstream. A flush drops everything and redirects the fetch PC.
//   clk, reset          - clock, async active-high reset
//   DIR, data_in        - upstream word valid / word
//   ack_prev            - one-cycle pulse after a word was taken
//   DOR, data_out,pc_out- head valid / head word / head PC
//   ack_from_next       - downstream consumed the head
//   flush, flush_pc     - redirect request / target
//   fetch_pc            - PC the next accepted word will carry
//   count               - occupancy
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DEPTH   = FETCH_DEPTH,
  parameter int PC_STEP = FETCH_PC_STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     DIR,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ack_prev,
  output logic                     DOR,
  output logic [DATA_W-1:0]        data_out,
  output logic [ADDR_W-1:0]        pc_out,
  input  logic                     ack_from_next,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_pc,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;

  fq_state_t         state, state_nxt;
  logic [CW-1:0]     count_nxt;
  logic [PW-1:0]     wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic              ack_nxt;
  logic              accept, pop;
  logic [EW-1:0]     head;

  // ack_prev gating the accept is what limits upstream to one word every
  // second cycle; it also keeps a held DIR from being taken twice.
  assign accept = DIR && (state != FQ_FULL) && (state != FQ_FLUSH) &&
                  !ack_prev && !flush;
  assign DOR    = (count != '0) && (state != FQ_FLUSH);
  assign pop    = DOR && ack_from_next && !flush;

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    fetch_pc_nxt = fetch_pc;
    ack_nxt      = 1'b0;
    if (flush) begin
      // Pointers restart at 0 so the queue is trivially empty.
      state_nxt    = FQ_FLUSH;
      count_nxt    = '0;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      fetch_pc_nxt = flush_pc;
    end else begin
      ack_nxt = accept;
      if (accept) begin
        wr_ptr_nxt   = wr_ptr + PW'(1);
        fetch_pc_nxt = fetch_pc + ADDR_W'(PC_STEP);
      end
      if (pop) rd_ptr_nxt = rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
      // FLUSH with flush released lands here with count 0 -> EMPTY.
      state_nxt = fq_occ_state(int'(count_nxt), DEPTH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FQ_EMPTY;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= '0;
      ack_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      fetch_pc <= fetch_pc_nxt;
      ack_prev <= ack_nxt;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata ({fetch_pc, data_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is unreset, so the head is masked to zero whenever not valid.
  assign data_out = DOR ? head[DATA_W-1:0]  : '0;
  assign pc_out   = DOR ? head[EW-1:DATA_W] : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;

  logic       clk, reset, DIR, ack_prev, DOR, ack_from_next, flush;
  logic [7:0] data_in, data_out, pc_out, flush_pc, fetch_pc;
  logic [2:0] count;

  int n_pass = 0;
  int n_total = 0;

  instruction_fetch_queue #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .PC_STEP(1)) dut (
    .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in), .ack_prev(ack_prev),
    .DOR(DOR), .data_out(data_out), .pc_out(pc_out), .ack_from_next(ack_from_next),
    .flush(flush), .flush_pc(flush_pc), .fetch_pc(fetch_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {pc,data} plus the fetch PC, the pending
  // ack pulse and whether the last edge was a flush.
  logic [15:0] mq[$];
  logic [7:0]  m_fpc;
  logic        m_ack, m_fl;

  task automatic model_clear();
    mq.delete(); m_fpc = 8'h00; m_ack = 1'b0; m_fl = 1'b0;
  endtask

  task automatic model_edge(input logic dir, input logic [7:0] din, input logic ack,
                            input logic fl, input logic [7:0] fpc);
    bit dor, acc, pp;
    dor = (mq.size() > 0) && !m_fl;
    if (fl) begin
      mq.delete(); m_fpc = fpc; m_ack = 1'b0; m_fl = 1'b1;
    end else begin
      acc = dir && (mq.size() < DEPTH) && !m_fl && !m_ack;
      pp  = dor && ack;
      if (pp) void'(mq.pop_front());
      if (acc) begin mq.push_back({m_fpc, din}); m_fpc = m_fpc + 8'd1; end
      m_ack = acc;
      m_fl  = 1'b0;
    end
  endtask

  // Drive inputs, take one edge, update the model, settle 1 time unit.
  task automatic step(input logic dir, input logic [7:0] din, input logic ack,
                      input logic fl, input logic [7:0] fpc);
    DIR = dir; data_in = din; ack_from_next = ack; flush = fl; flush_pc = fpc;
    @(posedge clk);
    model_edge(dir, din, ack, fl, fpc);
    #1;
  endtask

  task automatic do_reset();
    DIR = 0; data_in = 0; ack_from_next = 0; flush = 0; flush_pc = 0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({DOR, ack_prev, count, fetch_pc, data_out, pc_out} !== 29'd0)
      $display("FAIL reset_state got dor=%0b ack=%0b cnt=%0d fpc=%h d=%h pc=%h want all 0",
               DOR, ack_prev, count, fetch_pc, data_out, pc_out);
    else n_pass++;
  endtask

  task automatic test_first_word();
    do_reset();
    step(1, 8'h11, 0, 0, 0);
    n_total++; if (ack_prev !== 1'b1) $display("FAIL first_ack got %0b want 1", ack_prev); else n_pass++;
    n_total++; if ({DOR, data_out, pc_out, fetch_pc} !== {1'b1, 8'h11, 8'h00, 8'h01})
      $display("FAIL first_head got dor=%0b d=%h pc=%h fpc=%h want 1 11 00 01", DOR, data_out, pc_out, fetch_pc);
    else n_pass++;
    step(1, 8'h22, 0, 0, 0);
    n_total++; if (ack_prev !== 1'b0) $display("FAIL first_ack_pulse got %0b want 0", ack_prev); else n_pass++;
  endtask

  task automatic test_fill();
    int idx = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1, 8'hA0 + 8'(idx), 0, 0, 0);
      if (ack_prev) idx++;
    end
    n_total++; if (idx != 4) $display("FAIL fill_accepts got %0d want 4", idx); else n_pass++;
    n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else n_pass++;
    n_total++; if (fetch_pc !== 8'h04) $display("FAIL fill_fpc got %h want 04", fetch_pc); else n_pass++;
    step(1, 8'hA4, 1, 0, 0);  // pop A0, A4 blocked on this edge (still full)
    n_total++; if ({ack_prev, count} !== {1'b0, 3'd3}) $display("FAIL fill_pop got ack=%0b cnt=%0d want 0 3", ack_prev, count); else n_pass++;
    step(1, 8'hA4, 0, 0, 0);
    n_total++; if ({ack_prev, count} !== {1'b1, 3'd4}) $display("FAIL fill_a4 got ack=%0b cnt=%0d want 1 4", ack_prev, count); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_total++; if ({DOR, data_out, pc_out} !== {1'b1, 8'hA0 + 8'(k), 8'(k)})
        $display("FAIL fill_drain%0d got dor=%0b d=%h pc=%h want 1 %h %h", k, DOR, data_out, pc_out, 8'hA0 + 8'(k), 8'(k));
      else n_pass++;
      step(0, 0, 1, 0, 0);
    end
    n_total++; if ({DOR, count} !== {1'b0, 3'd0}) $display("FAIL fill_empty got dor=%0b cnt=%0d want 0 0", DOR, count); else n_pass++;
    step(0, 0, 1, 0, 0);  // ack while empty is ignored
    n_total++; if (count !== 3'd0) $display("FAIL underflow got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step(0, 0, 0, 1, 8'hFF);
    step(1, 8'h5A, 0, 0, 0);   // FLUSH cycle: no accept
    n_total++; if (ack_prev !== 1'b0) $display("FAIL wrap_flush_accept got %0b want 0", ack_prev); else n_pass++;
    step(1, 8'h5A, 0, 0, 0);
    n_total++; if ({ack_prev, pc_out, data_out, fetch_pc} !== {1'b1, 8'hFF, 8'h5A, 8'h00})
      $display("FAIL wrap got ack=%0b pc=%h d=%h fpc=%h want 1 ff 5a 00", ack_prev, pc_out, data_out, fetch_pc);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0); step(1, 8'h03, 0, 0, 0);
    n_total++; if (count !== 3'd2) $display("FAIL flush_pre got %0d want 2", count); else n_pass++;
    step(1, 8'h03, 1, 1, 8'h40);
    n_total++; if ({count, DOR, ack_prev, fetch_pc} !== {3'd0, 1'b0, 1'b0, 8'h40})
      $display("FAIL flush got cnt=%0d dor=%0b ack=%0b fpc=%h want 0 0 0 40", count, DOR, ack_prev, fetch_pc);
    else n_pass++;
    step(1, 8'h77, 0, 0, 0);
    n_total++; if ({DOR, ack_prev} !== 2'b00) $display("FAIL flush_hold got dor=%0b ack=%0b want 0 0", DOR, ack_prev); else n_pass++;
    step(1, 8'h77, 0, 0, 0);
    n_total++; if ({ack_prev, DOR, pc_out, data_out} !== {2'b11, 8'h40, 8'h77})
      $display("FAIL flush_next got ack=%0b dor=%0b pc=%h d=%h want 1 1 40 77", ack_prev, DOR, pc_out, data_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pcs[$];
    bit cnt_ok = 1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1, 8'($urandom), 1, 0, 0);
      if (ack_prev) pcs.push_back(pc_out);
      if (count > 3'd1) cnt_ok = 0;
    end
    n_total++; if (pcs.size() != 4) $display("FAIL b2b_rate got %0d want 4", pcs.size()); else n_pass++;
    n_total++; if (!cnt_ok) $display("FAIL b2b_count got >1 want <=1"); else n_pass++;
    for (int k = 0; k < 4 && k < pcs.size(); k++) begin
      n_total++; if (pcs[k] !== 8'(k)) $display("FAIL b2b_pc%0d got %h want %h", k, pcs[k], 8'(k)); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ed, ep;
    bit edor;
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 24) == 0, 8'($urandom));
      edor = (mq.size() > 0) && !m_fl;
      ed = edor ? mq[0][7:0] : 8'h00;
      ep = edor ? mq[0][15:8] : 8'h00;
      n_total++;
      if ({ack_prev, DOR, count, fetch_pc, data_out, pc_out} !== {m_ack, edor, 3'(mq.size()), m_fpc, ed, ep}) begin
        if (errs < 10)
          $display("FAIL random@%0d got ack=%0b dor=%0b cnt=%0d fpc=%h d=%h pc=%h want %0b %0b %0d %h %h %h",
                   c, ack_prev, DOR, count, fetch_pc, data_out, pc_out, m_ack, edor, mq.size(), m_fpc, ed, ep);
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) step(1, 8'(8'hC0 + c), 0, 0, 0);
    n_total++; if ({count, ack_prev} !== {3'd3, 1'b1}) $display("FAIL areset_pre got cnt=%0d ack=%0b want 3 1", count, ack_prev); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if ({DOR, ack_prev, count} !== 5'd0)
      $display("FAIL areset got dor=%0b ack=%0b cnt=%0d want 0 0 0", DOR, ack_prev, count);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    step(1, 8'h99, 0, 0, 0);
    n_total++; if ({ack_prev, pc_out, data_out} !== {1'b1, 8'h00, 8'h99})
      $display("FAIL areset_resume got ack=%0b pc=%h d=%h want 1 00 99", ack_prev, pc_out, data_out);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; DIR = 0; data_in = 0; ack_from_next = 0; flush = 0; flush_pc = 0;
    model_clear();
    test_reset();
    test_first_word();
    test_fill();
    test_pc_wrap();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
